axi_slave_mem: RTL

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem_if.sv | 78 +++++++
 rtl/axi_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem_if
//  Description : AXI4 (single-clock subset) bus bundle between a master and
//                the axi_slave_mem target. Carries the AW, W, B, AR and R
//                channels. Clock and reset are plain ports on the users.
//  Ports       : slave modport  - AW/W/AR requests and B/R ready in,
//                                 handshake readies and responses out
//                master modport - mirror image of slave
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_slave_mem_if #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int ID_BITS = 4
);
    localparam int NB = DATA_W / 8;

    // write address channel
    logic [ID_BITS-1:0] awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [7:0]         awlen;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;
    // write data channel
    logic [DATA_W-1:0]  wdata;
    logic [NB-1:0]      wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    // write response channel
    logic [ID_BITS-1:0] bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;
    // read address channel
    logic [ID_BITS-1:0] arid;
    logic [ADDR_W-1:0]  araddr;
    logic [7:0]         arlen;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    // read data channel
    logic [ID_BITS-1:0] rid;
    logic [DATA_W-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : AXI4 memory target. Independent write and read state
//                machines, one outstanding burst each, full-width beats,
//                FIXED / INCR / WRAP addressing, SLVERR on out-of-range
//                beats, protocol slips and unsupported bursts.
//  Ports       : clk   - single clock, rising edge
//                reset - synchronous, active-high
//                bus   - axi_slave_mem_if.slave (AW, W, B, AR, R channels)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ID_BITS = 4,
    parameter int RD_LAT  = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    axi_slave_mem_if.slave     bus
);
    localparam int c_NB        = DATA_W / 8;
    localparam int c_NB_LOG    = $clog2(c_NB);
    localparam int c_IDX_W     = $clog2(DEPTH);
    // R_WAIT holds for RD_LAT-1 cycles; the counter starts at RD_LAT-2
    localparam int c_WAIT_INIT = (RD_LAT > 2) ? (RD_LAT - 2) : 0;

    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // ------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------
    // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
    function automatic logic f_bad_burst(input logic [1:0] burst, input logic [7:0] len);
        logic legal_wrap;
        legal_wrap = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'd3) || ((burst == c_BURST_WRAP) && !legal_wrap);
    endfunction

    // Unsupported bursts step like INCR.
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [1:0]        burst,
                                                      input logic [7:0]        len);
        logic [ADDR_W-1:0] mask;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << c_NB_LOG) - ADDR_W'(1);
        if (burst == c_BURST_FIXED)
            return addr;
        else if ((burst == c_BURST_WRAP) && !f_bad_burst(burst, len))
            return (addr & ~mask) | ((addr + ADDR_W'(c_NB)) & mask);
        else
            return addr + ADDR_W'(c_NB);
    endfunction

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> c_NB_LOG) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_index(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = addr >> c_NB_LOG;
        return word[c_IDX_W-1:0];
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t           r_wstate;
    w_state_t           w_wstate_nxt;
    logic [ID_BITS-1:0] r_wid;
    logic [ADDR_W-1:0]  r_waddr;
    logic [7:0]         r_wlen;
    logic [1:0]         r_wburst;
    logic [7:0]         r_wcnt;
    logic               r_werr;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_wlast_beat;
    logic w_wbeat_in_range;
    logic w_wbeat_err;

    assign w_aw_hs          = bus.awvalid & bus.awready;
    assign w_w_hs           = bus.wvalid & bus.wready;
    // The burst ends on the counted beat; WLAST is only cross-checked.
    assign w_wlast_beat     = (r_wcnt == r_wlen);
    assign w_wbeat_in_range = f_in_range(r_waddr);
    assign w_wbeat_err      = !w_wbeat_in_range || (bus.wlast != w_wlast_beat);

    always_ff @(posedge clk) begin
        if (reset)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (bus.awvalid)                 w_wstate_nxt = W_DATA;
            W_DATA:  if (bus.wvalid && w_wlast_beat)  w_wstate_nxt = W_RESP;
            W_RESP:  if (bus.bready)                  w_wstate_nxt = W_IDLE;
            default:                                  w_wstate_nxt = W_IDLE;
        endcase

        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = c_RESP_OKAY;
        if (!reset) begin
            case (r_wstate)
                W_IDLE: bus.awready = 1'b1;
                W_DATA: bus.wready  = 1'b1;
                W_RESP: begin
                    bus.bvalid = 1'b1;
                    bus.bid    = r_wid;
                    bus.bresp  = r_werr ? c_RESP_SLVERR : c_RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wid    <= bus.awid;
                r_waddr  <= bus.awaddr;
                r_wlen   <= bus.awlen;
                r_wburst <= bus.awburst;
                r_wcnt   <= '0;
                r_werr   <= f_bad_burst(bus.awburst, bus.awlen);
            end
            if (w_w_hs) begin
                r_waddr <= f_next_addr(r_waddr, r_wburst, r_wlen);
                r_wcnt  <= r_wcnt + 8'd1;
                if (w_wbeat_err)
                    r_werr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t           r_rstate;
    r_state_t           w_rstate_nxt;
    logic [ID_BITS-1:0] r_rid;
    logic [ADDR_W-1:0]  r_raddr;   // address of the beat on (or about to be on) the bus
    logic [7:0]         r_rlen;
    logic [1:0]         r_rburst;
    logic [7:0]         r_rcnt;
    logic               r_rbad;
    logic [7:0]         r_rwait;
    logic [DATA_W-1:0]  r_rdata;
    logic [1:0]         r_rresp;
    logic               r_rlast;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_rd_load;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_last;
    logic              w_rd_bad;

    assign w_ar_hs = bus.arvalid & bus.arready;
    assign w_r_hs  = bus.rvalid & bus.rready;

    always_ff @(posedge clk) begin
        if (reset)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (bus.arvalid)             w_rstate_nxt = (RD_LAT == 1) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_rwait == 8'd0)         w_rstate_nxt = R_DATA;
            R_DATA:  if (bus.rready && r_rlast)   w_rstate_nxt = R_IDLE;
            default:                              w_rstate_nxt = R_IDLE;
        endcase

        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = c_RESP_OKAY;
        bus.rlast   = 1'b0;
        if (!reset) begin
            case (r_rstate)
                R_IDLE: bus.arready = 1'b1;
                R_DATA: begin
                    bus.rvalid = 1'b1;
                    bus.rid    = r_rid;
                    bus.rdata  = r_rdata;
                    bus.rresp  = r_rresp;
                    bus.rlast  = r_rlast;
                end
                default: ;
            endcase
        end
    end

    // The memory is sampled into the RDATA register one edge before the
    // beat is presented, and RDATA is then held until the handshake. A write
    // landing on the same edge as that sample is not seen by the read.
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_addr = r_raddr;
        w_rd_last = 1'b0;
        w_rd_bad  = r_rbad;
        case (r_rstate)
            R_IDLE: begin
                if ((RD_LAT == 1) && w_ar_hs) begin
                    w_rd_load = 1'b1;
                    w_rd_addr = bus.araddr;
                    w_rd_last = (bus.arlen == 8'd0);
                    w_rd_bad  = f_bad_burst(bus.arburst, bus.arlen);
                end
            end
            R_WAIT: begin
                if (r_rwait == 8'd0) begin
                    w_rd_load = 1'b1;
                    w_rd_last = (r_rlen == 8'd0);
                end
            end
            R_DATA: begin
                if (w_r_hs && !r_rlast) begin
                    w_rd_load = 1'b1;
                    w_rd_addr = f_next_addr(r_raddr, r_rburst, r_rlen);
                    w_rd_last = ((r_rcnt + 8'd1) == r_rlen);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rbad   <= 1'b0;
            r_rwait  <= '0;
            r_rresp  <= c_RESP_OKAY;
            r_rlast  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rid    <= bus.arid;
                r_raddr  <= bus.araddr;
                r_rlen   <= bus.arlen;
                r_rburst <= bus.arburst;
                r_rcnt   <= '0;
                r_rbad   <= f_bad_burst(bus.arburst, bus.arlen);
                r_rwait  <= 8'(c_WAIT_INIT);
            end
            if ((r_rstate == R_WAIT) && (r_rwait != 8'd0))
                r_rwait <= r_rwait - 8'd1;
            if (w_r_hs) begin
                r_raddr <= f_next_addr(r_raddr, r_rburst, r_rlen);
                r_rcnt  <= r_rcnt + 8'd1;
            end
            if (w_rd_load) begin
                r_rresp <= (w_rd_bad || !f_in_range(w_rd_addr)) ? c_RESP_SLVERR : c_RESP_OKAY;
                r_rlast <= w_rd_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset so contents survive a reset pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_w_hs && w_wbeat_in_range) begin
            for (int b = 0; b < c_NB; b++) begin
                if (bus.wstrb[b])
                    r_mem[f_index(r_waddr)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
        if (w_rd_load)
            r_rdata <= f_in_range(w_rd_addr) ? r_mem[f_index(w_rd_addr)] : '0;
    end
endmodule
`default_nettype wire
